// File: rtl/camera_ctrl_pkg.sv
// Shared types and helpers for the 2x2 pixel camera controller.
// Holds the sequencer state encoding, default exposure limits and the exposure clamp.
package camera_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXPOSE,
        READ_R1,
        READ_GAP,
        READ_R2
    } state_e;

    localparam int EXP_MIN_DEFAULT    = 2;
    localparam int EXP_MAX_DEFAULT    = 30;
    localparam int ROW_CYCLES_DEFAULT = 3;

    // Limits the register value to the exposure range the pixel array can use.
    function automatic logic [4:0] clamp_exp(input logic [4:0] value,
                                             input logic [4:0] lo,
                                             input logic [4:0] hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/camera_ctrl_fsm_row_read_seq.sv
// Row readout phase sequencer: counts the cycles a row select is held and
// strobes the ADC in the middle of the row. Reused for both rows.
module row_read_seq #(
    parameter int ROW_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic row_go,
    output logic row_active,
    output logic adc_pulse,
    output logic row_last
);

    localparam int PW = $clog2(ROW_CYCLES);
    localparam logic [PW-1:0] PHASE_LAST = PW'(ROW_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_ADC  = PW'(ROW_CYCLES / 2);

    logic [PW-1:0] phase_q, phase_d;
    logic          active_q, active_d;
    logic          adc_q, adc_d;

    // row_go says a row will be selected next cycle; phase restarts at 0 on each new row.
    always_comb begin
        phase_d  = '0;
        active_d = row_go;
        if (row_go && active_q && (phase_q != PHASE_LAST)) begin
            phase_d = phase_q + PW'(1);
        end
        adc_d = row_go && (phase_d == PHASE_ADC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= '0;
            active_q <= 1'b0;
            adc_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            adc_q    <= adc_d;
        end
    end

    assign row_active = active_q;
    assign adc_pulse  = adc_q;
    assign row_last   = (phase_q == PHASE_LAST);

endmodule

// File: rtl/camera_ctrl_fsm.sv
// Top-level capture sequencer: erase while idle, expose for the clamped
// exposure length, then read row 1, a gap cycle, and row 2.
module camera_ctrl_fsm
    import camera_ctrl_pkg::*;
#(
    parameter int EXP_MIN    = EXP_MIN_DEFAULT,
    parameter int EXP_MAX    = EXP_MAX_DEFAULT,
    parameter int ROW_CYCLES = ROW_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] init,
    input  logic       exp_start,
    output logic       erase,
    output logic       expose,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc,
    output logic       exp_done
);

    state_e     state_q, state_d;
    logic [4:0] exp_cnt_q, exp_cnt_d;
    logic       erase_q, erase_d;
    logic       expose_q, expose_d;
    logic       nre_1_q, nre_1_d;
    logic       nre_2_q, nre_2_d;
    logic       exp_done_q, exp_done_d;

    logic row_go;
    logic row_active;
    logic adc_pulse;
    logic row_last;
    logic row_end;

    assign row_end = row_active && row_last;

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (exp_start) begin
                    state_d   = EXPOSE;
                    exp_cnt_d = clamp_exp(init, 5'(EXP_MIN), 5'(EXP_MAX));
                end
            end
            EXPOSE: begin
                exp_cnt_d = exp_cnt_q - 5'd1;
                if (exp_cnt_q == 5'd1) begin
                    state_d = READ_R1;
                end
            end
            READ_R1: begin
                if (row_end) begin
                    state_d = READ_GAP;
                end
            end
            READ_GAP: state_d = READ_R2;
            READ_R2: begin
                if (row_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        row_go     = (state_d == READ_R1) || (state_d == READ_R2);
        erase_d    = (state_d == IDLE);
        expose_d   = (state_d == EXPOSE);
        nre_1_d    = (state_d != READ_R1);
        nre_2_d    = (state_d != READ_R2);
        exp_done_d = (state_q == READ_R2) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            exp_cnt_q  <= 5'd0;
            erase_q    <= 1'b1;
            expose_q   <= 1'b0;
            nre_1_q    <= 1'b1;
            nre_2_q    <= 1'b1;
            exp_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_cnt_q  <= exp_cnt_d;
            erase_q    <= erase_d;
            expose_q   <= expose_d;
            nre_1_q    <= nre_1_d;
            nre_2_q    <= nre_2_d;
            exp_done_q <= exp_done_d;
        end
    end

    row_read_seq #(
        .ROW_CYCLES(ROW_CYCLES)
    ) u_row_seq (
        .clk       (clk),
        .reset     (reset),
        .row_go    (row_go),
        .row_active(row_active),
        .adc_pulse (adc_pulse),
        .row_last  (row_last)
    );

    assign erase    = erase_q;
    assign expose   = expose_q;
    assign nre_1    = nre_1_q;
    assign nre_2    = nre_2_q;
    assign adc      = adc_pulse;
    assign exp_done = exp_done_q;

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Self-checking bench for camera_ctrl_fsm: directed scenarios plus random
// stimulus, compared each cycle against a capture-timeline reference model.
module tb_camera_ctrl_fsm;

    localparam int R = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] init;
    logic       exp_start;
    logic       erase, expose, nre_1, nre_2, adc, exp_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: one capture described by its start edge and length.
    int cyc        = 0;
    int cap_k      = 0;
    int cap_n      = 0;
    bit cap_active = 0;

    int done_count   = 0;
    int expose_count = 0;
    int first_done   = -1;
    int second_exp   = -1;

    camera_ctrl_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .exp_start(exp_start),
        .erase    (erase),
        .expose   (expose),
        .nre_1    (nre_1),
        .nre_2    (nre_2),
        .adc      (adc),
        .exp_done (exp_done)
    );

    always #5 clk = ~clk;

    function automatic int clampRef(input int v);
        if (v < 2) return 2;
        if (v > 30) return 30;
        return v;
    endfunction

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkOutput();
        int  d;
        bit  busy;
        bit  e_expose, e_nre1, e_nre2, e_adc, e_done;
        d        = cap_active ? (cyc - cap_k) : -1000;
        busy     = (d >= 1) && (d <= cap_n + 2 * R + 1);
        e_expose = (d >= 1) && (d <= cap_n);
        e_nre1   = !((d >= cap_n + 1) && (d <= cap_n + R));
        e_nre2   = !((d >= cap_n + R + 2) && (d <= cap_n + 2 * R + 1));
        e_adc    = (d == cap_n + 1 + R / 2) || (d == cap_n + R + 2 + R / 2);
        e_done   = (d == cap_n + 2 * R + 2);
        chk("erase", erase, !busy);
        chk("expose", expose, e_expose);
        chk("nre_1", nre_1, e_nre1);
        chk("nre_2", nre_2, e_nre2);
        chk("adc", adc, e_adc);
        chk("exp_done", exp_done, e_done);
        chk("inv_rows", (nre_1 === 1'b0) && (nre_2 === 1'b0), 1'b0);
        chk("inv_erase_expose", (erase === 1'b1) && (expose === 1'b1), 1'b0);
        if (exp_done === 1'b1) begin
            done_count++;
            if (first_done < 0) first_done = cyc;
        end
        if (expose === 1'b1) begin
            expose_count++;
            if (first_done >= 0 && second_exp < 0 && cyc > first_done) second_exp = cyc;
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic r, input logic s, input logic [4:0] iv);
        int d;
        reset     = r;
        exp_start = s;
        init      = iv;
        @(posedge clk);
        d = cap_k;
        d = cyc - d;
        if (r) begin
            cap_active = 0;
        end else if (s && !(cap_active && d >= 1 && d <= cap_n + 2 * R + 1)) begin
            cap_active = 1;
            cap_k      = cyc;
            cap_n      = clampRef(int'(iv));
        end
        cyc++;
        #1;
        checkOutput();
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed == expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int dc0, ec0;

        // Reset state, then the nominal init=5 capture with absolute cycle checks.
        applyStimulus(1, 0, 5'd0);
        applyStimulus(1, 0, 5'd0);
        applyStimulus(0, 1, 5'd5);
        for (int j = 1; j <= 14; j++) begin
            chk("t1_expose", expose, (j >= 1 && j <= 5));
            chk("t1_adc", adc, (j == 7 || j == 11));
            chk("t1_done", exp_done, (j == 13));
            applyStimulus(0, 0, 5'd5);
        end

        // Clamp cases.
        ec0 = expose_count;
        applyStimulus(0, 1, 5'd0);
        repeat (15) applyStimulus(0, 0, 5'd0);
        checkCount("clamp_low_len", expose_count - ec0, 2);
        ec0 = expose_count;
        applyStimulus(0, 1, 5'd31);
        repeat (45) applyStimulus(0, 0, 5'd31);
        checkCount("clamp_high_len", expose_count - ec0, 30);

        // init change mid-exposure and a start pulse during READ_R1 are ignored.
        ec0 = expose_count;
        dc0 = done_count;
        applyStimulus(0, 1, 5'd5);
        applyStimulus(0, 0, 5'd5);
        applyStimulus(0, 0, 5'd20);
        repeat (4) applyStimulus(0, 0, 5'd20);
        applyStimulus(0, 1, 5'd20);
        repeat (20) applyStimulus(0, 0, 5'd20);
        checkCount("ignore_len", expose_count - ec0, 5);
        checkCount("ignore_done", done_count - dc0, 1);

        // Back-to-back captures with exp_start held high.
        first_done = -1;
        second_exp = -1;
        repeat (40) applyStimulus(0, 1, 5'd2);
        repeat (20) applyStimulus(0, 0, 5'd2);
        checkCount("b2b_restart", second_exp - first_done, 1);

        // Reset during EXPOSE and during READ_R2 aborts without exp_done.
        dc0 = done_count;
        applyStimulus(0, 1, 5'd10);
        repeat (3) applyStimulus(0, 0, 5'd10);
        applyStimulus(1, 0, 5'd10);
        repeat (5) applyStimulus(0, 0, 5'd10);
        applyStimulus(0, 1, 5'd2);
        repeat (7) applyStimulus(0, 0, 5'd2);
        chk("r2_before_reset", nre_2, 1'b0);
        applyStimulus(1, 0, 5'd2);
        repeat (10) applyStimulus(0, 0, 5'd2);
        checkCount("abort_done", done_count - dc0, 0);

        // reset dominates exp_start in IDLE.
        ec0 = expose_count;
        repeat (3) applyStimulus(1, 1, 5'd5);
        checkCount("reset_dominates", expose_count - ec0, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/camera_ctrl_fsm.md
# camera_ctrl_fsm

Top-level sequencer for the 2×2 pixel camera.
- Accepts an exposure request and erases the pixel array while idle.
- Holds the array in exposure for the programmed number of cycles, then drives the two-row readout: row select plus an ADC strobe per row.
- Takes its exposure length from the exposure-time register and drives the pixel array and ADC control lines directly.

## Interface
- EXP_MIN, 2, lowest accepted exposure length in cycles
- EXP_MAX, 30, highest accepted exposure length in cycles
- ROW_CYCLES, 3, cycles each row-select is held low during readout (≥2)

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset, synchronous, active-high
- init  input  5  exposure length in cycles, from exposure-time register
- exp_start  input  1  level request to start one capture
- erase  output  1  high: pixel array held in erase
- expose  output  1  high: pixel array integrating
- nre_1  output  1  active-low row-1 read enable
- nre_2  output  1  active-low row-2 read enable
- adc  output  1  high for one cycle per row: ADC sample strobe
- exp_done  output  1  one-cycle pulse on return to IDLE after readout

## Operation
- Moore FSM. Outputs are decoded only from registered state and counters.
- States: IDLE, EXPOSE, READ_R1, READ_GAP, READ_R2.
- IDLE
  - Outputs: erase=1, expose=0, nre_1=nre_2=1, adc=0.
  - exp_start=1 at an edge moves to EXPOSE.
  - At that edge, exp_cnt loads clamp(init) into [EXP_MIN, EXP_MAX]: init<2 loads 2; init>30 loads 30.
- EXPOSE
  - Outputs: expose=1, erase=0.
  - exp_cnt decrements each cycle.
  - When exp_cnt==1, the state moves to READ_R1.
  - Result: the state is held exactly clamp(init) cycles.
- READ_R1
  - nre_1=0 for ROW_CYCLES cycles.
  - adc=1 on phase index ROW_CYCLES/2 (integer division) only.
- READ_GAP: one cycle, all read lines inactive, adc=0.
- READ_R2: same pattern as READ_R1 on nre_2, then IDLE.
- exp_done=1 in the first IDLE cycle after READ_R2 only.
- init is sampled only on the IDLE→EXPOSE edge. Later changes do not affect the capture in progress.
- exp_start outside IDLE is ignored and not queued.
- exp_start held high in IDLE, including the exp_done cycle, starts the next capture immediately, giving back-to-back captures.
- Never simultaneously asserted: nre_1 and nre_2 low, or erase and expose high.

## Timing
- Reset
  - reset=1 at an edge: state IDLE, exp_cnt=0, phase counter 0.
  - Resulting outputs: erase=1, expose=0, nre_1=1, nre_2=1, adc=0, exp_done=0.
  - Reset dominates every input, including mid-exposure and mid-readout; exp_done is not pulsed on an aborted capture.
- Capture timeline, with start accepted at edge k, N = clamp(init), R = ROW_CYCLES:
  - expose=1 in cycles k+1 … k+N.
  - nre_1=0 in cycles k+N+1 … k+N+R.
  - Gap cycle: k+N+R+1.
  - nre_2=0 in cycles k+N+R+2 … k+N+2R+1.
  - IDLE with exp_done=1 and erase=1 in cycle k+N+2R+2.
- Default parameters give a total capture of N+8 cycles from start to exp_done.
- Counter widths: exp_cnt 5 bits; phase counter $clog2(ROW_CYCLES) bits, wrapping to 0 on each row exit.

## Structure
- camera_ctrl_pkg holds:
  - the state enum typedef (IDLE, EXPOSE, READ_R1, READ_GAP, READ_R2);
  - EXP_MIN/EXP_MAX default localparams;
  - a clamp function.
- Sub-module row_read_seq: phase counter plus adc strobe decode.
  - Generic over ROW_CYCLES.
  - Takes row_go and returns row_active, adc_pulse and row_last.
  - Instantiated once and reused for both rows.

## Test plan
- Reset, then init=5, exp_start pulse at edge 0 → expose high cycles 1–5; nre_1 low 6–8 with adc at 7; gap 9; nre_2 low 10–12 with adc at 11; exp_done and erase at 13.
- Clamp cases:
  - init=0 → expose lasts exactly 2 cycles.
  - init=31 → expose lasts exactly 30 cycles.
- init changed 5→20 during EXPOSE, and exp_start re-pulsed during READ_R1 → exposure stays 5 cycles; a single exp_done; no second capture.
- exp_start held high for 40 cycles with init=2 → second expose begins the cycle after the first exp_done pulse. Check these invariants every cycle:
  - never nre_1 and nre_2 both low;
  - never erase and expose both high.
- Reset during EXPOSE, and separately during READ_R2 → next cycle is IDLE outputs, exp_done stays 0.
- reset and exp_start both high in IDLE → stays IDLE, expose stays 0.
